// File: rtl/rgb2ycbcr_coef_ctrl.sv
// Coefficient sequencer for rgb_2_ycbcr: a shadow bank filled by host writes or a preset
// sequencer, copied atomically into the active bank on the next vsync rising edge.
module rgb2ycbcr_coef_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COEF_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_wr_i,
  input  logic [3:0]                   cfg_addr_i,
  input  logic signed [COEF_WIDTH-1:0] cfg_wdata_i,
  output logic                         cfg_ready_o,
  input  logic [1:0]                   preset_sel_i,
  input  logic                         preset_load_i,
  input  logic                         commit_i,
  input  logic                         vs_i,
  output logic signed [COEF_WIDTH-1:0] coef_a00_o,
  output logic signed [COEF_WIDTH-1:0] coef_a01_o,
  output logic signed [COEF_WIDTH-1:0] coef_a02_o,
  output logic signed [COEF_WIDTH-1:0] coef_a10_o,
  output logic signed [COEF_WIDTH-1:0] coef_a11_o,
  output logic signed [COEF_WIDTH-1:0] coef_a12_o,
  output logic signed [COEF_WIDTH-1:0] coef_a20_o,
  output logic signed [COEF_WIDTH-1:0] coef_a21_o,
  output logic signed [COEF_WIDTH-1:0] coef_a22_o,
  output logic signed [COEF_WIDTH-1:0] coef_c0_o,
  output logic signed [COEF_WIDTH-1:0] coef_c1_o,
  output logic signed [COEF_WIDTH-1:0] coef_c2_o,
  output logic                         pending_o,
  output logic                         applied_o,
  output logic                         err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  localparam int OFS = 1 << (PIXEL_WIDTH - 1);

  state_t                      state;
  logic [3:0]                  cnt;
  logic [1:0]                  sel_q;
  logic                        commit_q;
  logic                        vs_q;
  logic signed [COEF_WIDTH-1:0] shadow [12];
  logic signed [COEF_WIDTH-1:0] active [12];

  // Q.10 preset table; sel 3 is never loaded and falls back to BT.601.
  function automatic logic signed [COEF_WIDTH-1:0] preset_coef(input logic [1:0] sel,
                                                               input logic [3:0] idx);
    int  v;
    logic bt709;
    bt709 = (sel == 2'd1);
    v = 0;
    case (idx)
      4'd0:         v = bt709 ? 218  : 306;
      4'd1:         v = bt709 ? 732  : 601;
      4'd2:         v = bt709 ? 74   : 117;
      4'd3:         v = bt709 ? -117 : -173;
      4'd4:         v = bt709 ? -395 : -339;
      4'd5, 4'd6:   v = 512;
      4'd7:         v = bt709 ? -465 : -429;
      4'd8:         v = bt709 ? -47  : -83;
      4'd10, 4'd11: v = OFS;
      default:      v = 0;
    endcase
    if (sel == 2'd2)
      v = (idx == 4'd0 || idx == 4'd4 || idx == 4'd8) ? 1024 : 0;
    return COEF_WIDTH'(v);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sel_q       <= 2'd0;
      commit_q    <= 1'b0;
      vs_q        <= 1'b0;
      cfg_ready_o <= 1'b1;
      pending_o   <= 1'b0;
      applied_o   <= 1'b0;
      err_o       <= 1'b0;
      for (int i = 0; i < 12; i++) begin
        shadow[i] <= preset_coef(2'd0, 4'(i));
        active[i] <= preset_coef(2'd0, 4'(i));
      end
    end else begin
      vs_q      <= vs_i;
      applied_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_wr_i) begin
            if (cfg_addr_i < 4'd12) shadow[cfg_addr_i] <= cfg_wdata_i;
            else                    err_o              <= 1'b1;
          end
          if (preset_load_i && preset_sel_i != 2'd3) begin
            state       <= LOAD;
            cnt         <= 4'd0;
            sel_q       <= preset_sel_i;
            commit_q    <= commit_i;
            cfg_ready_o <= 1'b0;
            pending_o   <= 1'b1;
          end else begin
            if (preset_load_i) err_o <= 1'b1;
            // A vs edge coinciding with the commit is deliberately not used.
            if (commit_i) begin
              state       <= ARMED;
              cfg_ready_o <= 1'b0;
              pending_o   <= 1'b1;
            end
          end
        end
        LOAD: begin
          shadow[cnt] <= preset_coef(sel_q, cnt);
          if (preset_load_i) err_o    <= 1'b1;
          if (commit_i)      commit_q <= 1'b1;
          if (cnt == 4'd11) begin
            if (commit_q || commit_i) begin
              state <= ARMED;
            end else begin
              state       <= IDLE;
              cfg_ready_o <= 1'b1;
              pending_o   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ARMED: begin
          if (preset_load_i) err_o <= 1'b1;
          if (vs_i && !vs_q) begin
            for (int i = 0; i < 12; i++) active[i] <= shadow[i];
            applied_o   <= 1'b1;
            commit_q    <= 1'b0;
            state       <= IDLE;
            cfg_ready_o <= 1'b1;
            pending_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign coef_a00_o = active[0];
  assign coef_a01_o = active[1];
  assign coef_a02_o = active[2];
  assign coef_a10_o = active[3];
  assign coef_a11_o = active[4];
  assign coef_a12_o = active[5];
  assign coef_a20_o = active[6];
  assign coef_a21_o = active[7];
  assign coef_a22_o = active[8];
  assign coef_c0_o  = active[9];
  assign coef_c1_o  = active[10];
  assign coef_c2_o  = active[11];

endmodule

// File: tb/tb_rgb2ycbcr_coef_ctrl.sv
// Scoreboard bench for rgb2ycbcr_coef_ctrl: expected active banks are queued on commit
// and compared whenever applied_o pulses; directed checks cover timing and error paths.
module tb_rgb2ycbcr_coef_ctrl;

  localparam int PW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_wr_i;
  logic [3:0] cfg_addr_i;
  logic signed [CW-1:0] cfg_wdata_i;
  logic cfg_ready_o;
  logic [1:0] preset_sel_i;
  logic preset_load_i;
  logic commit_i;
  logic vs_i;
  logic signed [CW-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22, c0, c1, c2;
  logic pending_o, applied_o, err_o;

  always #5 clk = ~clk;

  rgb2ycbcr_coef_ctrl #(.PIXEL_WIDTH(PW), .COEF_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_ready_o(cfg_ready_o),
    .preset_sel_i(preset_sel_i), .preset_load_i(preset_load_i),
    .commit_i(commit_i), .vs_i(vs_i),
    .coef_a00_o(a00), .coef_a01_o(a01), .coef_a02_o(a02),
    .coef_a10_o(a10), .coef_a11_o(a11), .coef_a12_o(a12),
    .coef_a20_o(a20), .coef_a21_o(a21), .coef_a22_o(a22),
    .coef_c0_o(c0), .coef_c1_o(c1), .coef_c2_o(c2),
    .pending_o(pending_o), .applied_o(applied_o), .err_o(err_o)
  );

  int bt601 [12] = '{306, 601, 117, -173, -339, 512, 512, -429, -83, 0, 128, 128};
  int bt709 [12] = '{218, 732, 74, -117, -395, 512, 512, -465, -47, 0, 128, 128};

  logic signed [CW-1:0] mdl [12];
  logic [12*CW-1:0] exp_q [$];
  logic [12*CW-1:0] obs_bank;
  logic [12*CW-1:0] mon_e;
  int n_checks = 0;
  int n_err = 0;

  assign obs_bank = {c2, c1, c0, a22, a21, a20, a12, a11, a10, a02, a01, a00};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [12*CW-1:0] pack_mdl();
    logic [12*CW-1:0] r;
    for (int i = 0; i < 12; i++) r[i*CW +: CW] = mdl[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int d);
    cfg_wr_i    = 1'b1;
    cfg_addr_i  = 4'(addr);
    cfg_wdata_i = CW'(d);
    tick();
    cfg_wr_i = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // Every applied pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && applied_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("applied_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 12; i++)
          chk($sformatf("bank[%0d]", i), $signed(obs_bank[i*CW +: CW]),
              $signed(mon_e[i*CW +: CW]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; cfg_wr_i = 1'b0; cfg_addr_i = 4'd0; cfg_wdata_i = '0;
    preset_sel_i = 2'd0; preset_load_i = 1'b0; commit_i = 1'b0; vs_i = 1'b0;
    for (int i = 0; i < 12; i++) mdl[i] = CW'(bt601[i]);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_a00", a00, 306);
    chk("rst_a21", a21, -429);
    chk("rst_c1", c1, 128);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_pending", pending_o, 0);
    chk("rst_applied", applied_o, 0);
    chk("rst_err", err_o, 0);

    // Host write, commit, vs edge
    wr(0, 500);
    mdl[0] = 500;
    commit();
    chk("armed_pending", pending_o, 1);
    chk("armed_ready", cfg_ready_o, 0);
    exp_q.push_back(pack_mdl());
    vs_i = 1'b1;
    chk("a00_before_edge", a00, 306);
    tick();
    chk("edge_applied", applied_o, 1);
    chk("edge_a00", a00, 500);
    vs_i = 1'b0;
    tick();
    chk("applied_one_cycle", applied_o, 0);
    chk("after_pending", pending_o, 0);
    chk("after_ready", cfg_ready_o, 1);

    // BT.709 preset load with simultaneous commit; writes during load ignored
    preset_sel_i = 2'd1; preset_load_i = 1'b1; commit_i = 1'b1;
    tick();
    preset_load_i = 1'b0; commit_i = 1'b0; preset_sel_i = 2'd0;
    cfg_wr_i = 1'b1; cfg_addr_i = 4'd0; cfg_wdata_i = CW'(777);
    for (int k = 0; k < 12; k++) begin
      chk("load_pending", pending_o, 1);
      chk("load_ready", cfg_ready_o, 0);
      tick();
    end
    cfg_wr_i = 1'b0;
    chk("load_to_armed_pending", pending_o, 1);
    chk("load_no_err", err_o, 0);
    for (int i = 0; i < 12; i++) mdl[i] = CW'(bt709[i]);
    exp_q.push_back(pack_mdl());
    vs_i = 1'b1;
    tick();
    chk("bt709_applied", applied_o, 1);
    chk("bt709_a00", a00, 218);
    chk("bt709_a11", a11, -395);
    chk("bt709_a22", a22, -47);
    vs_i = 1'b0;
    tick();

    // Commit coinciding with a vs edge waits for the next edge; held vs no retrigger
    wr(4, 1000);
    mdl[4] = 1000;
    commit_i = 1'b1; vs_i = 1'b1;
    tick();
    commit_i = 1'b0;
    repeat (3) begin
      chk("held_vs_applied", applied_o, 0);
      chk("held_vs_a11", a11, -395);
      tick();
    end
    chk("held_vs_pending", pending_o, 1);
    vs_i = 1'b0;
    tick();
    exp_q.push_back(pack_mdl());
    vs_i = 1'b1;
    tick();
    chk("next_edge_applied", applied_o, 1);
    chk("next_edge_a11", a11, 1000);
    vs_i = 1'b0;
    tick();

    // Rejected requests
    wr(13, 55);
    chk("bad_addr_err", err_o, 1);
    tick();
    chk("bad_addr_err_clear", err_o, 0);
    preset_sel_i = 2'd3; preset_load_i = 1'b1;
    tick();
    preset_load_i = 1'b0; preset_sel_i = 2'd0;
    chk("bad_sel_err", err_o, 1);
    chk("bad_sel_ready", cfg_ready_o, 1);
    chk("bad_sel_pending", pending_o, 0);
    tick();
    chk("bad_sel_err_clear", err_o, 0);
    commit();
    exp_q.push_back(pack_mdl());
    vs_i = 1'b1;
    tick();
    chk("err_commit_applied", applied_o, 1);
    vs_i = 1'b0;
    tick();

    // Asynchronous reset while armed
    wr(0, 42);
    commit();
    chk("pre_rst_pending", pending_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a00", a00, 306);
    chk("async_rst_a11", a11, -339);
    chk("async_rst_pending", pending_o, 0);
    chk("async_rst_ready", cfg_ready_o, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) mdl[i] = CW'(bt601[i]);
    tick();
    vs_i = 1'b1;
    tick();
    chk("rst_no_applied", applied_o, 0);
    chk("rst_keep_a00", a00, 306);
    vs_i = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
